// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control-step sequencer.
// Drives one-hot bus-drive strobes, register/datapath load enables, ALU
// function and memory read request for a small fixed instruction subset.
// Ports:
//   clock, clear      - system clock; asynchronous active-high reset
//   start             - leave IDLE and begin fetching (sampled in IDLE only)
//   mem_ready         - memory read data valid (sampled in WAIT only)
//   ir[31:0]          - instruction register: op[31:27] ra[26:23] rb[22:19] rc[18:15]
//   r_out[15:0]       - one-hot register bus drive (bit n = Rnout)
//   HIout..Cout       - special bus-drive strobes
//   r_in[15:0]        - one-hot register load enable (bit n = Rnin)
//   PCin..Zin         - datapath load enables
//   IncPC, Read       - ALU PC+1 select, memory read request
//   alu_op[3:0]       - ALU function (0 ADD, 1 SUB, 2 AND, 3 OR)
//   run               - high in every state except IDLE and HALT
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [15:0] r_out,
  output logic        HIout,
  output logic        LOout,
  output logic        zhighout,
  output logic        zlowout,
  output logic        PCout,
  output logic        MDRout,
  output logic        InPortout,
  output logic        Cout,
  output logic [15:0] r_in,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        IncPC,
  output logic        Read,
  output logic [3:0]  alu_op,
  output logic        run
);

  localparam int unsigned RegW = 16;

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpIn   = 5'b10110;
  localparam logic [4:0] OpMfhi = 5'b10111;
  localparam logic [4:0] OpMflo = 5'b11000;
  localparam logic [4:0] OpHalt = 5'b11011;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_WAIT, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_e;

  state_e state_q, state_d;

  logic [4:0]      opcode;
  logic [RegW-1:0] ra_oh, rb_oh, rc_oh;
  logic            is_alu, is_addi, is_xfer;
  logic            unused_ir_bits;

  // Field decode; ir is only consulted in T2..T5.
  assign opcode  = ir[31:27];
  assign ra_oh   = RegW'(1) << ir[26:23];
  assign rb_oh   = RegW'(1) << ir[22:19];
  assign rc_oh   = RegW'(1) << ir[18:15];
  assign is_alu  = (opcode == OpAdd) || (opcode == OpSub) ||
                   (opcode == OpAnd) || (opcode == OpOr);
  assign is_addi = (opcode == OpAddi);
  assign is_xfer = (opcode == OpIn) || (opcode == OpMfhi) || (opcode == OpMflo);
  assign unused_ir_bits = ^ir[14:0];

  // State register; clear forces IDLE immediately.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and control decode.
  always_comb begin
    state_d   = state_q;
    r_out     = '0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    zhighout  = 1'b0;
    zlowout   = 1'b0;
    PCout     = 1'b0;
    MDRout    = 1'b0;
    InPortout = 1'b0;
    Cout      = 1'b0;
    r_in      = '0;
    PCin      = 1'b0;
    IRin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    alu_op    = AluAdd;
    run       = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        run = 1'b0;
        if (start) state_d = S_T0;
      end
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        Read = 1'b1;
        if (mem_ready) begin
          MDRin   = 1'b1;
          state_d = S_T2;
        end
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        if (is_alu || is_addi || is_xfer) state_d = S_T3;
        else if (opcode == OpHalt)        state_d = S_HALT;
        else                              state_d = S_T0;
      end
      S_T3: begin
        state_d = S_T0;
        if (is_alu || is_addi) begin
          r_out   = rb_oh;
          Yin     = 1'b1;
          state_d = S_T4;
        end else if (opcode == OpMfhi) begin
          HIout = 1'b1;
          r_in  = ra_oh;
        end else if (opcode == OpMflo) begin
          LOout = 1'b1;
          r_in  = ra_oh;
        end else if (opcode == OpIn) begin
          InPortout = 1'b1;
          r_in      = ra_oh;
        end
      end
      S_T4: begin
        state_d = S_T5;
        Zin     = 1'b1;
        if (is_addi) begin
          Cout = 1'b1;
        end else begin
          r_out = rc_oh;
          unique case (opcode)
            OpSub:   alu_op = AluSub;
            OpAnd:   alu_op = AluAnd;
            OpOr:    alu_op = AluOr;
            default: alu_op = AluAdd;
          endcase
        end
      end
      S_T5: begin
        zlowout = 1'b1;
        r_in    = ra_oh;
        state_d = S_T0;
      end
      S_HALT: begin
        run = 1'b0;
      end
      default: begin
        run     = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
